// File: rtl/mem_bank_arbiter.sv
// Two-master round-robin arbiter with bounded burst hold for the three-bank data memory.
// Issues one access per cycle: registered bank strobes at N+1, response beat at N+2.
module mem_bank_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BANK_LSB  = 12,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_valid,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic          m0_rvalid,
  output logic          m0_err,
  input  logic          m1_valid,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic          m1_rvalid,
  output logic          m1_err,
  output logic [DW-1:0] rdata,
  output logic [1:0]    MemorySelector,
  output logic          MemWrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {NONE, OWN0, OWN1} owner_t;

  owner_t        ownerQ, ownerD;
  logic [CW-1:0] cntQ, cntD;
  logic          lastM1Q, lastM1D;
  logic          gnt0, gnt1;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] c);
    if (c >= CW'(MAX_BURST)) return CW'(MAX_BURST);
    return c + 1'b1;
  endfunction

  // Bank 00 is read-only; bank 11 is unmapped.
  function automatic logic bankErr(input logic [1:0] fld, input logic wr);
    return (fld == 2'b11) || ((fld == 2'b00) && wr);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ownerQ  <= NONE;
      cntQ    <= '0;
      lastM1Q <= 1'b1;
    end else begin
      ownerQ  <= ownerD;
      cntQ    <= cntD;
      lastM1Q <= lastM1D;
    end
  end

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    ownerD  = ownerQ;
    cntD    = cntQ;
    lastM1D = lastM1Q;
    case (ownerQ)
      OWN0: begin
        if (m0_valid && ((cntQ < CW'(MAX_BURST)) || !m1_valid)) gnt0 = 1'b1;
        else if (m1_valid) gnt1 = 1'b1;
      end
      OWN1: begin
        if (m1_valid && ((cntQ < CW'(MAX_BURST)) || !m0_valid)) gnt1 = 1'b1;
        else if (m0_valid) gnt0 = 1'b1;
      end
      default: begin
        if (m0_valid && m1_valid) begin
          gnt0 = lastM1Q;
          gnt1 = !lastM1Q;
        end else begin
          gnt0 = m0_valid;
          gnt1 = m1_valid;
        end
      end
    endcase

    if (gnt0) begin
      lastM1D = 1'b0;
      if (ownerQ == OWN0) cntD = satInc(cntQ);
      else begin
        ownerD = OWN0;
        cntD   = CW'(1);
      end
    end else if (gnt1) begin
      lastM1D = 1'b1;
      if (ownerQ == OWN1) cntD = satInc(cntQ);
      else begin
        ownerD = OWN1;
        cntD   = CW'(1);
      end
    end else if ((ownerQ == OWN0 && !m0_valid) || (ownerQ == OWN1 && !m1_valid)) begin
      ownerD = NONE;
      cntD   = '0;
    end
  end

  assign m0_ready = gnt0;
  assign m1_ready = gnt1;

  // Stage p0: accepted request selection and decode
  logic          accept_p0, write_p0, err_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] wdata_p0;
  logic [1:0]    fld_p0;

  assign accept_p0 = gnt0 | gnt1;
  assign write_p0  = gnt1 ? m1_write : m0_write;
  assign addr_p0   = gnt1 ? m1_addr  : m0_addr;
  assign wdata_p0  = gnt1 ? m1_wdata : m0_wdata;
  assign fld_p0    = addr_p0[BANK_LSB+1:BANK_LSB];
  assign err_p0    = bankErr(fld_p0, write_p0);

  // Stage p1: issued access on the bank interface
  logic vld_p1, src_p1, err_p1, write_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1         <= 1'b0;
      src_p1         <= 1'b0;
      err_p1         <= 1'b0;
      write_p1       <= 1'b0;
      MemWrite       <= 1'b0;
      MemorySelector <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      vld_p1   <= accept_p0;
      MemWrite <= accept_p0 & write_p0 & !err_p0;
      if (accept_p0) begin
        src_p1         <= gnt1;
        err_p1         <= err_p0;
        write_p1       <= write_p0;
        MemorySelector <= fld_p0;
        mem_addr       <= addr_p0;
        mem_wdata      <= wdata_p0;
      end
    end
  end

  // Stage p2: response beat; bank read data arrives this cycle
  logic rdOk_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      rdOk_p2   <= 1'b0;
    end else begin
      m0_rvalid <= vld_p1 & !src_p1;
      m1_rvalid <= vld_p1 & src_p1;
      m0_err    <= vld_p1 & !src_p1 & err_p1;
      m1_err    <= vld_p1 & src_p1 & err_p1;
      rdOk_p2   <= vld_p1 & !write_p1 & !err_p1;
    end
  end

  assign rdata = rdOk_p2 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Scoreboard bench for mem_bank_arbiter: directed requests push expected issue/response
// beats; negedge monitors pop and compare as the DUT presents them.
module tb_mem_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 0, m0_write = 0, m1_valid = 0, m1_write = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] memRdata = 0;
  logic [1:0]  MemorySelector;
  logic        MemWrite;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  sel;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } issue_t;

  typedef struct {
    int          cyc;
    logic        who;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  issue_t iq[$];
  resp_t  rq[$];

  mem_bank_arbiter #(.AW(32), .DW(32), .BANK_LSB(12), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
    .rdata(rdata), .MemorySelector(MemorySelector), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(memRdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic expErr(input logic [31:0] a, input logic w);
    return (a[13:12] == 2'b11) || (a[13:12] == 2'b00 && w);
  endfunction

  task automatic pushExp(input logic who, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic e;
    e = expErr(a, w);
    iq.push_back('{cyc + 1, a[13:12], w && !e, a, d});
    rq.push_back('{cyc + 2, who, e, (w || e) ? 32'h0 : memRdata});
  endtask

  // One request cycle: drive, check the expected grant, push expectations for the accepted beat.
  task automatic step(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic e0, input logic e1, input bit push);
    @(posedge clk);
    #1;
    m0_valid = v0; m0_write = w0; m0_addr = a0; m0_wdata = d0;
    m1_valid = v1; m1_write = w1; m1_addr = a1; m1_wdata = d1;
    #3;
    chk("ready pair", {m0_ready, m1_ready}, {e0, e1});
    if (push && e0) pushExp(1'b0, w0, a0, d0);
    if (push && e1) pushExp(1'b1, w1, a1, d1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Issue-side monitor
  always @(negedge clk) begin
    if (m0_ready && m1_ready) begin
      errors++;
      $display("FAIL both ready actual=11 expected=one-hot (cycle %0d)", cyc);
    end
    if (iq.size() > 0 && iq[0].cyc == cyc) begin
      issue_t x;
      x = iq.pop_front();
      chk("MemorySelector", MemorySelector, x.sel);
      chk("MemWrite", MemWrite, x.mw);
      chk("mem_addr", mem_addr, x.addr);
      if (x.mw) chk("mem_wdata", mem_wdata, x.wdata);
    end else if (MemWrite) begin
      errors++;
      $display("FAIL spurious MemWrite actual=1 expected=0 (cycle %0d)", cyc);
    end
  end

  // Response-side monitor
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected rvalid actual=%b%b expected=00 (cycle %0d)", m0_rvalid, m1_rvalid, cyc);
      end else begin
        resp_t r;
        r = rq.pop_front();
        chk("resp cycle", 64'(cyc), 64'(r.cyc));
        chk("rvalid pair", {m0_rvalid, m1_rvalid}, {!r.who, r.who});
        chk("err pair", {m0_err, m1_err}, {!r.who && r.err, r.who && r.err});
        chk("rdata", rdata, r.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset MemorySelector", MemorySelector, 0);
    chk("reset MemWrite", MemWrite, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset rvalid/err", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 0);
    chk("reset rdata", rdata, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // m0 write to bank 01, then m1 read of bank 10
    step(1, 1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 1);
    idle(1);
    memRdata = 32'h1234_5678;
    step(0, 0, 0, 0, 1, 0, 32'h0000_2000, 0, 0, 1, 1);
    idle(3);

    // Both masters continuously valid: m0 x4, m1 x4, m0 x4, m1 x4
    for (int i = 0; i < 16; i++)
      step(1, 1, 32'h0000_1100 + 4 * i, 32'hA000_0000 + i,
           1, 1, 32'h0000_1200 + 4 * i, 32'hB000_0000 + i,
           ((i / 4) % 2) == 0, ((i / 4) % 2) == 1, 1);
    idle(3);

    // Error accesses: write to read-only bank 00, read of unmapped bank 11
    memRdata = 32'hFFFF_FFFF;
    step(1, 1, 32'h0000_0010, 32'h5555_AAAA, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 32'h0000_3000, 0, 0, 1, 1);
    idle(3);

    // m1 alone for 10 beats, then m0 joins: m1 already saturated, so m0 wins at once
    memRdata = 32'h0BAD_F00D;
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 0, 1, 0, 32'h0000_2000 + 4 * i, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++)
      step(1, 1, 32'h0000_1300 + 4 * i, 32'hC000_0000 + i,
           1, 0, 32'h0000_2100 + 4 * i, 0, i < 4, i >= 4, 1);
    idle(3);

    // Reset while an accepted write is on the bank interface
    step(1, 1, 32'h0000_1008, 32'h1111_2222, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #2;
    chk("pre-reset MemWrite", MemWrite, 1);
    chk("pre-reset mem_addr", mem_addr, 32'h0000_1008);
    reset = 1'b1;
    m0_valid = 0;
    #1;
    chk("async MemWrite", MemWrite, 0);
    chk("async mem_addr", mem_addr, 0);
    chk("async MemorySelector", MemorySelector, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    idle(3);
    memRdata = 32'h0000_00C3;
    step(0, 0, 0, 0, 1, 0, 32'h0000_2040, 0, 0, 1, 1);
    step(1, 1, 32'h0000_2004, 32'h7777_8888, 0, 0, 0, 0, 1, 0, 1);
    idle(4);

    chk("issue queue drained", 64'(iq.size()), 0);
    chk("response queue drained", 64'(rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
